sub_arbiter: RTL and testbench

SUB_ARBITER -- requirements
Module: sub_arbiter

---
 rtl/sub_arbiter.sv | 116 +++++++++++
 tb/tb_sub_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/sub_arbiter.sv
// Two-requester round-robin subtractor with a single registered response.
// Operands are extended to N+1 bits so the top bit reports borrow/overflow.
module sub_arbiter #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req0_valid_i,
  input  logic         req1_valid_i,
  output logic         req0_ready_o,
  output logic         req1_ready_o,
  input  logic         req0_sign_i,
  input  logic         req1_sign_i,
  input  logic [N-1:0] req0_data0_i,
  input  logic [N-1:0] req0_data1_i,
  input  logic [N-1:0] req1_data0_i,
  input  logic [N-1:0] req1_data1_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [N-1:0] rsp_data_o,
  output logic         rsp_over_o,
  output logic         rsp_id_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  localparam logic [N:0] ONE = (N+1)'(1);

  state_t       state_q, state_d;
  logic         last_q;
  logic         own_q;
  logic         sign_q;
  logic [N-1:0] a_q, b_q;
  logic [N-1:0] data_q;
  logic         over_q;
  logic         id_q;

  logic         is_idle;
  logic         any_v;
  logic         gnt1;
  logic         accept;
  logic [N:0]   ext_a, ext_b, diff;

  assign is_idle = (state_q == IDLE);
  assign any_v   = req0_valid_i | req1_valid_i;

  // Requester 1 wins when alone, or on a tie if 0 was granted last.
  assign gnt1    = req1_valid_i & (~req0_valid_i | ~last_q);
  assign accept  = is_idle & any_v;

  assign req0_ready_o = is_idle & req0_valid_i & ~gnt1;
  assign req1_ready_o = is_idle & gnt1;

  assign ext_a = {sign_q & a_q[N-1], a_q};
  assign ext_b = {sign_q & b_q[N-1], b_q};
  assign diff  = ext_a + ~ext_b + ONE;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (any_v) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
      own_q  <= 1'b0;
      sign_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (accept) begin
      last_q <= gnt1;
      own_q  <= gnt1;
      sign_q <= gnt1 ? req1_sign_i  : req0_sign_i;
      a_q    <= gnt1 ? req1_data0_i : req0_data0_i;
      b_q    <= gnt1 ? req1_data1_i : req0_data1_i;
    end
  end

  // Response fields only move in EXEC so they hold steady elsewhere.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      over_q <= 1'b0;
      id_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      data_q <= diff[N-1:0];
      over_q <= diff[N];
      id_q   <= own_q;
    end
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = data_q;
  assign rsp_over_o  = over_q;
  assign rsp_id_o    = id_q;
  assign busy_o      = ~is_idle;

endmodule

// File: tb/tb_sub_arbiter.sv
// Random scoreboard bench for sub_arbiter against a transaction-level model.
// Driver predicts acceptances; a monitor pops and compares each response.
module tb_sub_arbiter;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] data;
    logic         over;
    logic         id;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         r0v, r1v, r0s, r1s;
  logic         r0rdy, r1rdy;
  logic [N-1:0] r0a, r0b, r1a, r1b;
  logic         rsp_valid, rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_over, rsp_id, busy;

  int vectors = 0;
  int errors  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  sub_arbiter #(.N(N)) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .req0_valid_i(r0v),
    .req1_valid_i(r1v),
    .req0_ready_o(r0rdy),
    .req1_ready_o(r1rdy),
    .req0_sign_i(r0s),
    .req1_sign_i(r1s),
    .req0_data0_i(r0a),
    .req0_data1_i(r0b),
    .req1_data0_i(r1a),
    .req1_data1_i(r1b),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data),
    .rsp_over_o(rsp_over),
    .rsp_id_o(rsp_id),
    .busy_o(busy)
  );

  task automatic chk(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t ref_sub(input logic s, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic id);
    longint ea, eb, d;
    logic [N:0] r;
    exp_t e;
    ea = longint'(a);
    eb = longint'(b);
    if (s && a[N-1]) ea = ea - (longint'(1) << N);
    if (s && b[N-1]) eb = eb - (longint'(1) << N);
    d = ea - eb;
    r = d[N:0];
    e.data = r[N-1:0];
    e.over = r[N];
    e.id = id;
    return e;
  endfunction

  // Directed operations: {requester, sign, data0, data1}
  logic [N-1:0] dir_a [3] = '{8'h05, 8'h03, 8'h80};
  logic [N-1:0] dir_b [3] = '{8'h03, 8'h05, 8'h01};
  logic         dir_s [3] = '{1'b0, 1'b0, 1'b1};
  logic         dir_id[3] = '{1'b0, 1'b0, 1'b1};

  initial begin
    bit in_flight;
    bit last;
    bit free, vis, g, any;
    int age;
    int dir_idx;
    rst_ni = 1'b0;
    {r0v, r1v, r0s, r1s, rsp_ready} = '0;
    {r0a, r0b, r1a, r1b} = '0;
    in_flight = 0;
    last = 1;
    age = 0;
    dir_idx = 0;
    #1;
    chk("reset_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_over", rsp_over, 0);
    chk("reset_id", rsp_id, 0);
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      if (in_flight) age++;
      vis = in_flight && age >= 2;
      if (c >= 300 && vis && (c % 41 == 0)) begin
        rst_ni = 1'b0;
        #1;
        chk("rst_drop_valid", rsp_valid, 0);
        chk("rst_drop_busy", busy, 0);
        chk("rst_drop_data", rsp_data, 0);
        q.delete();
        in_flight = 0;
        last = 1;
        vis = 0;
        rst_ni = 1'b1;
      end
      if (dir_idx < 3) begin
        r0v = !dir_id[dir_idx];
        r1v = dir_id[dir_idx];
        r0s = dir_s[dir_idx];
        r1s = dir_s[dir_idx];
        r0a = dir_a[dir_idx];
        r1a = dir_a[dir_idx];
        r0b = dir_b[dir_idx];
        r1b = dir_b[dir_idx];
        rsp_ready = 1'b1;
      end else begin
        r0s = 1'($urandom);
        r1s = 1'($urandom);
        r0a = N'($urandom);
        r0b = N'($urandom);
        r1a = N'($urandom);
        r1b = N'($urandom);
        if (c < 200) begin
          r0v = 1'b1;
          r1v = 1'b1;
          rsp_ready = 1'b1;
        end else begin
          r0v = ($urandom_range(0, 3) != 0);
          r1v = ($urandom_range(0, 3) != 0);
          rsp_ready = ((c / 8) % 3 == 0) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
        end
      end
      #1;
      free = !in_flight;
      any = r0v || r1v;
      g = (r0v && r1v) ? !last : r1v;
      chk("ready0", r0rdy, free && any && !g);
      chk("ready1", r1rdy, free && any && g);
      chk("rsp_valid", rsp_valid, vis);
      chk("busy", busy, in_flight);
      if (free && any) begin
        if (g) q.push_back(ref_sub(r1s, r1a, r1b, 1'b1));
        else   q.push_back(ref_sub(r0s, r0a, r0b, 1'b0));
        last = g;
        in_flight = 1;
        age = 0;
        if (dir_idx < 3) dir_idx++;
      end else if (vis && rsp_ready) begin
        in_flight = 0;
      end
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          e = q[0];
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_over", rsp_over, e.over);
          chk("rsp_id", rsp_id, e.id);
          if (rsp_ready) void'(q.pop_front());
        end
      end
    end
  end

endmodule
